// File: rtl/jtdsp16_pkg.sv
// Shared codes and helpers for the jtdsp16 Y-space address arithmetic unit.
package jtdsp16_pkg;

    // Post-modify selection codes
    localparam logic [1:0] MOD_NONE = 2'd0;
    localparam logic [1:0] MOD_INC  = 2'd1;
    localparam logic [1:0] MOD_DEC  = 2'd2;
    localparam logic [1:0] MOD_J    = 2'd3;

    // Register select codes
    localparam logic [2:0] REG_R0 = 3'd0;
    localparam logic [2:0] REG_R1 = 3'd1;
    localparam logic [2:0] REG_R2 = 3'd2;
    localparam logic [2:0] REG_R3 = 3'd3;
    localparam logic [2:0] REG_RB = 3'd4;
    localparam logic [2:0] REG_RE = 3'd5;
    localparam logic [2:0] REG_J  = 3'd6;
    localparam logic [2:0] REG_K  = 3'd7;

    // Exchange access sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XWR  = 1'b1
    } yaau_state_e;

    // New pointer value after an access. Only +1 wraps, and only when a
    // non-zero end bound is programmed and the pointer sits exactly on it.
    function automatic logic [15:0] post_modify(
        input logic [15:0] cur,
        input logic [1:0]  mode,
        input logic [15:0] step,
        input logic [15:0] rb,
        input logic [15:0] re
    );
        logic [15:0] res;
        case (mode)
            MOD_NONE: res = cur;
            MOD_INC: begin
                if ((re != 16'd0) && (cur == re)) begin
                    res = rb;
                end else begin
                    res = cur + 16'd1;
                end
            end
            MOD_DEC: res = cur - 16'd1;
            MOD_J:   res = cur + step;
            default: res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/jtdsp16_ram.sv
// Single-port synchronous data RAM. A write cycle leaves dout untouched so
// the last read word stays available to the DAU across writes.
module jtdsp16_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   din,
    output logic [15:0]   dout
);

    logic [15:0] mem [2**AW];
    logic [15:0] dout_q;

    // Storage array: contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (cen && we) begin
            mem[addr] <= din;
        end
    end

    // Read register: samples the word before any write on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= 16'd0;
        end else if (cen && !we) begin
            dout_q <= mem[addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/jtdsp16_yaau.sv
// Y-space address arithmetic unit: pointer file, circular-buffer bounds,
// increments, the data RAM and the two-cycle exchange sequencer.
module jtdsp16_yaau
    import jtdsp16_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        acc_en,
    input  logic        acc_we,
    input  logic        acc_xchg,
    input  logic [1:0]  ptr_sel,
    input  logic [1:0]  mod_sel,
    input  logic        inc_k,
    input  logic [15:0] dau_dout,
    input  logic        reg_we,
    input  logic [2:0]  reg_sel,
    input  logic [15:0] reg_din,
    output logic [15:0] reg_dout,
    output logic [15:0] ram_dout,
    output logic        busy
);

    yaau_state_e   state_q, state_d;
    logic [AW-1:0] xaddr_q, xaddr_d;
    logic [1:0]    xptr_q,  xptr_d;
    logic [15:0]   r_q [4];
    logic [15:0]   r_d [4];
    logic [15:0]   rb_q, rb_d, re_q, re_d, j_q, j_d, k_q, k_d;

    logic          ram_en_s;
    logic          ram_we_s;
    logic [AW-1:0] ram_addr_s;
    logic          mod_en_s;
    logic [1:0]    mod_ptr_s;

    // Access sequencing, post-modify and register loads for the next edge
    always_comb begin
        state_d    = state_q;
        xaddr_d    = xaddr_q;
        xptr_d     = xptr_q;
        r_d        = r_q;
        rb_d       = rb_q;
        re_d       = re_q;
        j_d        = j_q;
        k_d        = k_q;
        ram_en_s   = 1'b0;
        ram_we_s   = 1'b0;
        ram_addr_s = r_q[ptr_sel][AW-1:0];
        mod_en_s   = 1'b0;
        mod_ptr_s  = ptr_sel;

        case (state_q)
            ST_IDLE: begin
                if (acc_en) begin
                    ram_en_s = 1'b1;
                    if (acc_xchg) begin
                        // Read now; pointer update waits for the write half
                        xaddr_d = r_q[ptr_sel][AW-1:0];
                        xptr_d  = ptr_sel;
                        state_d = ST_XWR;
                    end else begin
                        ram_we_s = acc_we;
                        mod_en_s = 1'b1;
                    end
                end else begin
                    ram_en_s = 1'b0;
                end
            end
            ST_XWR: begin
                ram_en_s   = 1'b1;
                ram_we_s   = 1'b1;
                ram_addr_s = xaddr_q;
                mod_en_s   = 1'b1;
                mod_ptr_s  = xptr_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (mod_en_s) begin
            r_d[mod_ptr_s] = post_modify(r_q[mod_ptr_s], mod_sel,
                                         inc_k ? k_q : j_q, rb_q, re_q);
        end else begin
            r_d[mod_ptr_s] = r_q[mod_ptr_s];
        end

        // Loads come last so a load to the pointer being modified wins
        if (reg_we) begin
            case (reg_sel)
                REG_R0:  r_d[0] = reg_din;
                REG_R1:  r_d[1] = reg_din;
                REG_R2:  r_d[2] = reg_din;
                REG_R3:  r_d[3] = reg_din;
                REG_RB:  rb_d   = reg_din;
                REG_RE:  re_d   = reg_din;
                REG_J:   j_d    = reg_din;
                REG_K:   k_d    = reg_din;
                default: rb_d   = rb_q;
            endcase
        end else begin
            rb_d = rb_q;
        end
    end

    // State and register file update, gated by the clock enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            xaddr_q <= '0;
            xptr_q  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= 16'd0;
            end
            rb_q <= 16'd0;
            re_q <= 16'd0;
            j_q  <= 16'd0;
            k_q  <= 16'd0;
        end else if (cen) begin
            state_q <= state_d;
            xaddr_q <= xaddr_d;
            xptr_q  <= xptr_d;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= r_d[i];
            end
            rb_q <= rb_d;
            re_q <= re_d;
            j_q  <= j_d;
            k_q  <= k_d;
        end
    end

    // Register read-back of the current (pre-edge) values
    always_comb begin
        case (reg_sel)
            REG_R0:  reg_dout = r_q[0];
            REG_R1:  reg_dout = r_q[1];
            REG_R2:  reg_dout = r_q[2];
            REG_R3:  reg_dout = r_q[3];
            REG_RB:  reg_dout = rb_q;
            REG_RE:  reg_dout = re_q;
            REG_J:   reg_dout = j_q;
            REG_K:   reg_dout = k_q;
            default: reg_dout = 16'd0;
        endcase
    end

    assign busy = (state_q == ST_XWR);

    jtdsp16_ram #(
        .AW (AW)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen & ram_en_s),
        .we   (ram_we_s),
        .addr (ram_addr_s),
        .din  (dau_dout),
        .dout (ram_dout)
    );

endmodule

// File: tb/tb_jtdsp16_yaau.sv
// Scoreboard bench for jtdsp16_yaau: stimulus tasks update a behavioural
// model and queue the expected post-edge outputs; a monitor compares them.
module tb_jtdsp16_yaau;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        acc_en = 1'b0, acc_we = 1'b0, acc_xchg = 1'b0;
    logic [1:0]  ptr_sel = 2'd0, mod_sel = 2'd0;
    logic        inc_k = 1'b0;
    logic [15:0] dau_dout = 16'd0;
    logic        reg_we = 1'b0;
    logic [2:0]  reg_sel = 3'd0;
    logic [15:0] reg_din = 16'd0;
    logic [15:0] reg_dout, ram_dout;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    typedef struct {
        int          cyc;
        logic [15:0] dout;
        bit          dchk;
        bit          busy;
        logic [2:0]  rsel;
        logic [15:0] rview;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    // Behavioural model: index 0-3 pointers, 4 rb, 5 re, 6 j, 7 k
    logic [15:0] mr [8];
    logic [15:0] mmem [2048];
    bit          mknown [2048];
    bit          m_x = 1'b0;
    int          m_xaddr = 0;
    int          m_xptr = 0;
    logic [15:0] m_dout = 16'd0;
    bit          m_dk = 1'b1;

    jtdsp16_yaau #(.AW(11)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .acc_en   (acc_en),
        .acc_we   (acc_we),
        .acc_xchg (acc_xchg),
        .ptr_sel  (ptr_sel),
        .mod_sel  (mod_sel),
        .inc_k    (inc_k),
        .dau_dout (dau_dout),
        .reg_we   (reg_we),
        .reg_sel  (reg_sel),
        .reg_din  (reg_din),
        .reg_dout (reg_dout),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Pointer arithmetic straight from the rules, in plain integers
    function automatic logic [15:0] newptr(input logic [15:0] cur, input logic [1:0] md,
                                           input bit ik, input logic [15:0] b, input logic [15:0] e,
                                           input logic [15:0] jj, input logic [15:0] kk);
        int v;
        int stepv;
        if (md == 2'd1) begin
            if (e != 16'd0 && cur == e) v = int'(b);
            else v = int'(cur) + 1;
        end else if (md == 2'd2) begin
            v = int'(cur) - 1;
        end else if (md == 2'd3) begin
            stepv = ik ? int'(kk) : int'(jj);
            if (stepv >= 32768) stepv = stepv - 65536;
            v = int'(cur) + stepv;
        end else begin
            v = int'(cur);
        end
        v = ((v % 65536) + 65536) % 65536;
        return v[15:0];
    endfunction

    task automatic step(input bit c, input bit en, input bit we, input bit x,
                        input logic [1:0] p, input logic [1:0] md, input bit ik,
                        input logic [15:0] dau, input bit rwe, input logic [2:0] rs,
                        input logic [15:0] rd);
        exp_t e;
        logic [15:0] pre [8];
        int a;
        @(negedge clk);
        cen = c; acc_en = en; acc_we = we; acc_xchg = x; ptr_sel = p; mod_sel = md;
        inc_k = ik; dau_dout = dau; reg_we = rwe; reg_sel = rs; reg_din = rd;
        ncyc++;
        pre = mr;
        if (c) begin
            if (m_x) begin
                mmem[m_xaddr] = dau;
                mknown[m_xaddr] = 1'b1;
                mr[m_xptr] = newptr(pre[m_xptr], md, ik, pre[4], pre[5], pre[6], pre[7]);
                m_x = 1'b0;
            end else if (en) begin
                a = int'(pre[p]) % 2048;
                if (x) begin
                    m_dout = mmem[a]; m_dk = mknown[a];
                    m_x = 1'b1; m_xaddr = a; m_xptr = int'(p);
                end else if (we) begin
                    mmem[a] = dau; mknown[a] = 1'b1;
                    mr[p] = newptr(pre[p], md, ik, pre[4], pre[5], pre[6], pre[7]);
                end else begin
                    m_dout = mmem[a]; m_dk = mknown[a];
                    mr[p] = newptr(pre[p], md, ik, pre[4], pre[5], pre[6], pre[7]);
                end
            end
            if (rwe) mr[rs] = rd;
        end
        e.cyc = ncyc; e.dout = m_dout; e.dchk = m_dk; e.busy = m_x;
        e.rsel = rs; e.rview = mr[rs];
        sbq.push_back(e);
    endtask

    task automatic ld(input logic [2:0] rs, input logic [15:0] v);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd0, 1'b1, rs, v);
    endtask

    task automatic acc(input logic [1:0] p, input logic [1:0] md, input bit ik, input bit we,
                       input bit x, input logic [15:0] dau);
        step(1'b1, 1'b1, we, x, p, md, ik, dau, 1'b0, {1'b0, p}, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cen = 1'b1; acc_en = 1'b0; reg_we = 1'b0;
        for (int i = 0; i < 8; i++) mr[i] = 16'd0;
        m_x = 1'b0; m_dout = 16'd0; m_dk = 1'b1;
        #1;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_ram_dout", ram_dout, 16'd0);
        for (int s = 0; s < 8; s++) begin
            reg_sel = s[2:0];
            #1;
            chk($sformatf("rst_reg%0d", s), reg_dout, 16'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare every queued post-edge expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk($sformatf("c%0d_busy", mon_e.cyc), {15'd0, busy}, {15'd0, mon_e.busy});
                chk($sformatf("c%0d_reg%0d", mon_e.cyc, mon_e.rsel), reg_dout, mon_e.rview);
                if (mon_e.dchk) chk($sformatf("c%0d_ram_dout", mon_e.cyc), ram_dout, mon_e.dout);
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) mr[i] = 16'd0;
        for (int i = 0; i < 2048; i++) begin
            mmem[i] = 16'd0;
            mknown[i] = 1'b0;
        end
        do_reset();

        // Write then read back through r0
        ld(3'd0, 16'd5);
        acc(2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 16'h1234);
        acc(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0000);
        acc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Circular +1 with and without an end bound
        ld(3'd4, 16'd10); ld(3'd5, 16'd12); ld(3'd1, 16'd10);
        repeat (4) acc(2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000);
        ld(3'd5, 16'd0); ld(3'd1, 16'd10);
        repeat (4) acc(2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Negative j and address truncation
        ld(3'd6, 16'hFFFE); ld(3'd2, 16'd3);
        acc(2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 16'h0000);
        acc(2'd2, 2'd3, 1'b0, 1'b1, 1'b0, 16'h0B0B);
        acc(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 16'hC0DE);
        ld(3'd0, 16'd1);
        acc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
        ld(3'd0, 16'h07FF);
        acc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Exchange on r3
        ld(3'd3, 16'd20);
        acc(2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 16'hAAAA);
        acc(2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 16'h5555);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 16'h5555, 1'b0, 3'd3, 16'd0);
        ld(3'd0, 16'd20);
        acc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Load beats post-modify on the same pointer
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 16'd0, 1'b1, 3'd0, 16'd100);

        // Clock enable dropped in the write half of an exchange
        ld(3'd0, 16'd30);
        acc(2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h1357);
        acc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 16'h7777, 1'b0, 3'd0, 16'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 16'h9999, 1'b0, 3'd0, 16'd0);
        ld(3'd0, 16'd30);
        acc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Reset while in the write half: no write happens
        ld(3'd0, 16'd40);
        acc(2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h1111);
        acc(2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 16'h2222);
        do_reset();
        ld(3'd0, 16'd40);
        acc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] rv;
            logic [15:0] dv;
            rv = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            dv = 16'($urandom);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) == 0, 2'($urandom), 2'($urandom), 1'($urandom),
                 dv, $urandom_range(0, 4) == 0, 3'($urandom), rv);
        end

        repeat (2) @(negedge clk);
        chk("sb_drain", 16'(sbq.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
